bundler_seq: RTL and testbench

Sequencer that drives one `bundler_bits` instance across a full hypervector of `DIM` bits, `PAR_BITS` bits per pass. Fetches each chunk of the `NUM_HVS` input hypervectors and the two tie-break vectors from a synchronous read port, then pulses the bundler and waits for its `done`. Writes each bundled chunk to an output write port. Sits between HV storage and the bundler in the encoder datapath.

---
 rtl/hdc_pkg.sv | 22 ++
 rtl/bseq_watchdog.sv | 30 +++
 rtl/bundler_seq.sv | 137 +++++++++++++
 tb/tb_bundler_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// Shared types and helpers for the HDC encoder datapath.
// Holds the bundler-sequencer state encoding and the chunk address width helper.
package hdc_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StIssue,
        StWait,
        StWrite,
        StFin
    } bseq_state_t;

    // Width of a chunk index; never narrower than one bit.
    function automatic int unsigned chunk_aw(input int unsigned dim, input int unsigned par_bits);
        int unsigned n;
        n = dim / par_bits;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bseq_watchdog.sv
// Loadable down-counter bounding how long the sequencer waits on the bundler.
// The expiry flag marks the last permitted wait cycle.
module bseq_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic nrst,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] count_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CntW'(TIMEOUT);
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    // Count holds 1 during the TIMEOUT-th wait cycle.
    assign expired = (count_q == CntW'(1));

endmodule

// File: rtl/bundler_seq.sv
// Walks a full hypervector chunk by chunk: fetch, load the bundler, wait for it,
// write the bundled chunk back. All outputs are registered.
module bundler_seq
    import hdc_pkg::*;
#(
    parameter int unsigned DIM      = 1024,
    parameter int unsigned NUM_HVS  = 6,
    parameter int unsigned PAR_BITS = 2,
    parameter int unsigned TIMEOUT  = 64,
    localparam int unsigned CW      = chunk_aw(DIM, PAR_BITS)
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               start,
    input  logic                               abort,
    output logic                               busy,
    output logic                               done,
    output logic                               error,
    output logic                               rd_en,
    output logic [CW-1:0]                      rd_addr,
    input  logic [NUM_HVS-1:0][PAR_BITS-1:0]   rd_bits,
    input  logic [PAR_BITS-1:0]                rd_ties_1,
    input  logic [PAR_BITS-1:0]                rd_ties_2,
    output logic                               wr_en,
    output logic [CW-1:0]                      wr_addr,
    output logic [PAR_BITS-1:0]                wr_data,
    output logic                               bb_en,
    output logic [NUM_HVS-1:0][PAR_BITS-1:0]   bb_bits,
    output logic [PAR_BITS-1:0]                bb_ties_1,
    output logic [PAR_BITS-1:0]                bb_ties_2,
    input  logic                               bb_done,
    input  logic [PAR_BITS-1:0]                bb_out_bits
);

    if (DIM % PAR_BITS != 0) begin : g_dim_check
        $error("bundler_seq: DIM must be a multiple of PAR_BITS");
    end

    localparam logic [CW-1:0] LastIdx = CW'(DIM / PAR_BITS - 1);

    bseq_state_t   state;
    logic [CW-1:0] idx;
    logic          wd_expired;

    bseq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .nrst    (nrst),
        .load    (state == StIssue),
        .dec     (state == StWait),
        .expired (wd_expired)
    );

    // Outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= StIdle;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            bb_en     <= 1'b0;
            bb_bits   <= '0;
            bb_ties_1 <= '0;
            bb_ties_2 <= '0;
        end else begin
            rd_en <= 1'b0;
            bb_en <= 1'b0;
            wr_en <= 1'b0;
            done  <= 1'b0;
            if ((state != StIdle) && abort) begin
                state <= StIdle;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (start) begin
                            state   <= StFetch;
                            idx     <= '0;
                            rd_addr <= '0;
                            rd_en   <= 1'b1;
                            busy    <= 1'b1;
                            error   <= 1'b0;
                        end
                    end
                    StFetch: state <= StLoad;
                    StLoad: begin
                        bb_bits   <= rd_bits;
                        bb_ties_1 <= rd_ties_1;
                        bb_ties_2 <= rd_ties_2;
                        bb_en     <= 1'b1;
                        state     <= StIssue;
                    end
                    StIssue: state <= StWait;
                    StWait: begin
                        if (bb_done) begin
                            wr_data <= bb_out_bits;
                            wr_addr <= idx;
                            wr_en   <= 1'b1;
                            state   <= StWrite;
                        end else if (wd_expired) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= StIdle;
                        end
                    end
                    StWrite: begin
                        if (idx == LastIdx) begin
                            done  <= 1'b1;
                            state <= StFin;
                        end else begin
                            idx     <= idx + 1'b1;
                            rd_addr <= idx + 1'b1;
                            rd_en   <= 1'b1;
                            state   <= StFetch;
                        end
                    end
                    StFin: begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bundler_seq.sv
// Directed bench for bundler_seq: DIM=8, PAR_BITS=2, six HVs, majority stub with latency 3.
module tb_bundler_seq;

    localparam int unsigned DIM      = 8;
    localparam int unsigned NUM_HVS  = 6;
    localparam int unsigned PAR_BITS = 2;
    localparam int unsigned TIMEOUT  = 5;
    localparam int unsigned CW       = 2;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, error, rd_en, wr_en, bb_en, bb_done;
    logic [CW-1:0] rd_addr, wr_addr;
    logic [NUM_HVS-1:0][PAR_BITS-1:0] rd_bits, bb_bits, stub_bits;
    logic [PAR_BITS-1:0] rd_ties_1, rd_ties_2, wr_data, bb_ties_1, bb_ties_2;
    logic [PAR_BITS-1:0] bb_out_bits, stub_t1, stub_t2;
    logic [1:0] stub_cnt;
    logic hang = 1'b0;
    logic spur = 1'b0;

    int checks = 0;
    int failures = 0;
    int nwr;

    logic [1:0] exp_wd [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

    always #5 clk = ~clk;

    bundler_seq #(
        .DIM      (DIM),
        .NUM_HVS  (NUM_HVS),
        .PAR_BITS (PAR_BITS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_bits     (rd_bits),
        .rd_ties_1   (rd_ties_1),
        .rd_ties_2   (rd_ties_2),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .bb_en       (bb_en),
        .bb_bits     (bb_bits),
        .bb_ties_1   (bb_ties_1),
        .bb_ties_2   (bb_ties_2),
        .bb_done     (bb_done),
        .bb_out_bits (bb_out_bits)
    );

    // Memory: chunk k, hv j = base[j] + k with base {0,0,1,0,0,3}; ties k and 3k.
    function automatic logic [1:0] mem_hv(input int j, input logic [1:0] k);
        case (j)
            2: return 2'd1 + k;
            5: return 2'd3 + k;
            default: return k;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rd_en) begin
            for (int j = 0; j < NUM_HVS; j++) rd_bits[j] <= mem_hv(j, rd_addr);
            rd_ties_1 <= rd_addr;
            rd_ties_2 <= rd_addr * 2'd3;
        end else begin
            rd_bits   <= '1;
            rd_ties_1 <= '1;
            rd_ties_2 <= '1;
        end
    end

    // Bundler stub: done 3 cycles after the bb_en cycle, majority with xor tie-break.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stub_cnt  <= 2'd0;
            stub_bits <= '0;
            stub_t1   <= '0;
            stub_t2   <= '0;
        end else if (bb_en) begin
            stub_cnt  <= 2'd1;
            stub_bits <= bb_bits;
            stub_t1   <= bb_ties_1;
            stub_t2   <= bb_ties_2;
        end else if (stub_cnt == 2'd3) begin
            stub_cnt <= 2'd0;
        end else if (stub_cnt != 2'd0) begin
            stub_cnt <= stub_cnt + 2'd1;
        end
    end

    function automatic logic [1:0] maj(input logic [NUM_HVS-1:0][PAR_BITS-1:0] b,
                                       input logic [1:0] t1, input logic [1:0] t2);
        logic [1:0] r;
        int ones;
        r = 2'b00;
        for (int p = 0; p < PAR_BITS; p++) begin
            ones = 0;
            for (int j = 0; j < NUM_HVS; j++) ones += int'(b[j][p]);
            if (ones > 3) r[p] = 1'b1;
            else if (ones == 3) r[p] = t1[p] ^ t2[p];
        end
        return r;
    endfunction

    assign bb_done     = ((stub_cnt == 2'd3) && !hang) || spur;
    assign bb_out_bits = maj(stub_bits, stub_t1, stub_t2);

    task automatic chk(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 1 of the new operation.
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, done, error, rd_en, rd_addr, wr_en, wr_addr, wr_data,
                    bb_en, bb_bits, bb_ties_1, bb_ties_2});
    endfunction

    initial begin
        #2;
        chk("reset_outs", 0, all_outs(), 32'd0);
        step();
        nrst = 1'b1;
        step();
        step();
        chk("idle_outs", 0, all_outs(), 32'd0);

        // Full run with start collisions and a spurious bb_done in FETCH.
        nwr = 0;
        pulse_start();
        for (int c = 1; c <= 31; c++) begin
            chk("busy", c, busy, (c <= 29));
            chk("done", c, done, (c == 29));
            chk("rd_en", c, rd_en, ((c % 7 == 1) && c <= 22));
            if ((c % 7 == 1) && c <= 22) chk("rd_addr", c, rd_addr, (c - 1) / 7);
            chk("bb_en", c, bb_en, ((c % 7 == 3) && c <= 24));
            chk("wr_en", c, wr_en, ((c % 7 == 0) && c >= 7 && c <= 28));
            if ((c % 7 == 0) && c >= 7 && c <= 28) begin
                chk("wr_addr", c, wr_addr, c / 7 - 1);
                chk("wr_data", c, wr_data, exp_wd[c / 7 - 1]);
            end
            if (c >= 3 && c <= 9) begin
                chk("hold_bits0", c, bb_bits, 12'hC10);
                chk("hold_ties0", c, {bb_ties_1, bb_ties_2}, 4'b0000);
            end
            if (c >= 10 && c <= 16) begin
                chk("hold_bits1", c, bb_bits, 12'h165);
                chk("hold_ties1", c, {bb_ties_1, bb_ties_2}, 4'b0111);
            end
            if (wr_en) nwr++;
            start = (c == 5 || c == 12);
            spur  = (c == 8);
            step();
        end
        start = 1'b0;
        spur  = 1'b0;
        chk("write_count", 31, nwr, 4);
        step();

        // Timeout: stub never answers.
        hang = 1'b1;
        pulse_start();
        for (int c = 1; c <= 12; c++) begin
            chk("to_busy", c, busy, (c <= 8));
            chk("to_error", c, error, (c >= 9));
            chk("to_wr_en", c, wr_en, 1'b0);
            chk("to_done", c, done, 1'b0);
            step();
        end
        hang = 1'b0;

        // Abort in chunk 2 WAIT; also confirms error clears on start.
        pulse_start();
        for (int c = 1; c <= 24; c++) begin
            chk("ab_error", c, error, 1'b0);
            chk("ab_busy", c, busy, (c <= 19));
            chk("ab_wr_en", c, wr_en, (c == 7 || c == 14));
            if (c == 7 || c == 14) chk("ab_wr_addr", c, wr_addr, c / 7 - 1);
            chk("ab_done", c, done, 1'b0);
            abort = (c == 19);
            step();
        end
        abort = 1'b0;

        // Restart rewrites from chunk 0, then reset lands in chunk 1 WAIT.
        pulse_start();
        for (int c = 1; c <= 11; c++) begin
            chk("rw_wr_en", c, wr_en, (c == 7));
            if (c == 7) begin
                chk("rw_wr_addr", c, wr_addr, 0);
                chk("rw_wr_data", c, wr_data, 2'b00);
            end
            step();
        end
        chk("rw_busy", 12, busy, 1'b1);
        chk("rw_bits1", 12, bb_bits, 12'h165);
        nrst = 1'b0;
        #1;
        chk("async_reset_outs", 12, all_outs(), 32'd0);
        #2;
        nrst = 1'b1;
        step();
        step();
        chk("post_reset_outs", 14, all_outs(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
